// File: rtl/dualram_pkg.sv
// Shared defaults and state type for the dual-port RAM bank.
package dualram_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 1024;
  localparam int DEFAULT_BASE  = 206800;
  localparam int DEFAULT_AW    = 32;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dualram_port.sv
// One access port: address range check, index generation and the registered response.
module dualram_port
  import dualram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int BASE  = DEFAULT_BASE,
  parameter int AW    = DEFAULT_AW,
  parameter int IW    = idx_bits(DEFAULT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             ready,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] word,
  output logic [IW-1:0]    idx,
  output logic             wr_en,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             err
);

  localparam logic [AW-1:0] BASE_W  = AW'(BASE);
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  logic [AW-1:0] offset;
  logic          in_range;
  logic          accept;

  // Underflow is caught by the explicit compare, so a wrapped offset never aliases a valid index.
  always_comb begin
    offset   = addr - BASE_W;
    in_range = (addr >= BASE_W) && (offset < DEPTH_W);
    accept   = req & ready;
    idx      = offset[IW-1:0];
    wr_en    = accept & we & in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= accept;
      err    <= accept & ~in_range;
      rdata  <= (accept && !we && in_range) ? word : '0;
    end
  end

endmodule

// File: rtl/dualram_bank.sv
// Two-port byte-writable RAM bank with read-first ports and port-A write priority.
// Define DUALRAM_CLEAR_EN to zero the memory after every reset before accepting requests.
module dualram_bank
  import dualram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int BASE  = DEFAULT_BASE,
  parameter int AW    = DEFAULT_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_a,
  input  logic               req_b,
  input  logic               we_a,
  input  logic               we_b,
  input  logic [WIDTH/8-1:0] be_a,
  input  logic [WIDTH/8-1:0] be_b,
  input  logic [AW-1:0]      addr_a,
  input  logic [AW-1:0]      addr_b,
  input  logic [WIDTH-1:0]   wdata_a,
  input  logic [WIDTH-1:0]   wdata_b,
  output logic               ready_a,
  output logic               ready_b,
  output logic               rvalid_a,
  output logic               rvalid_b,
  output logic [WIDTH-1:0]   rdata_a,
  output logic [WIDTH-1:0]   rdata_b,
  output logic               err_a,
  output logic               err_b,
  output logic               init_busy
);

  localparam int IW = idx_bits(DEPTH);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    idx_a, idx_b;
  logic             wr_a, wr_b;
  logic             run;
  logic             clearing;
  logic [IW-1:0]    clr_idx;

`ifdef DUALRAM_CLEAR_EN
  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == S_CLEAR && clr_idx == IW'(DEPTH - 1)) state_next = S_RUN;
  end

  always_comb begin
    run       = (state == S_RUN);
    init_busy = (state == S_CLEAR);
    clearing  = (state == S_CLEAR) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst)                    clr_idx <= '0;
    else if (state == S_CLEAR)  clr_idx <= clr_idx + 1'b1;
  end
`else
  assign run       = 1'b1;
  assign init_busy = 1'b0;
  assign clearing  = 1'b0;
  assign clr_idx   = '0;
`endif

  assign ready_a = run & ~rst;
  assign ready_b = run & ~rst;

  dualram_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE), .AW(AW), .IW(IW)) u_port_a (
    .clk(clk), .rst(rst), .req(req_a), .ready(ready_a), .we(we_a), .addr(addr_a),
    .word(mem[idx_a]), .idx(idx_a), .wr_en(wr_a),
    .rvalid(rvalid_a), .rdata(rdata_a), .err(err_a)
  );

  dualram_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE), .AW(AW), .IW(IW)) u_port_b (
    .clk(clk), .rst(rst), .req(req_b), .ready(ready_b), .we(we_b), .addr(addr_b),
    .word(mem[idx_b]), .idx(idx_b), .wr_en(wr_b),
    .rvalid(rvalid_b), .rdata(rdata_b), .err(err_b)
  );

  // Port A's byte assignment comes last so it wins any same-index, same-byte collision.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_idx] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wr_b && be_b[b]) mem[idx_b][b*8 +: 8] <= wdata_b[b*8 +: 8];
        if (wr_a && be_a[b]) mem[idx_a][b*8 +: 8] <= wdata_a[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dualram_bank.sv
// Directed self-checking bench for dualram_bank (DEPTH=16); clear checks run when DUALRAM_CLEAR_EN is defined.
module tb_dualram_bank;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int BASE  = 206800;
  localparam int AW    = 32;
  localparam logic [31:0] B = 32'(BASE);

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b, we_a, we_b;
  logic [3:0]       be_a, be_b;
  logic [AW-1:0]    addr_a, addr_b;
  logic [WIDTH-1:0] wdata_a, wdata_b;
  logic             ready_a, ready_b, rvalid_a, rvalid_b, err_a, err_b, init_busy;
  logic [WIDTH-1:0] rdata_a, rdata_b;

  int tests_run    = 0;
  int tests_failed = 0;

  dualram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .be_a(be_a), .be_b(be_b), .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ready_a(ready_a), .ready_b(ready_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .err_a(err_a), .err_b(err_b),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit port_b, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (!port_b) begin
      req_a = 1'b1; we_a = we; be_a = be; addr_a = addr; wdata_a = wdata;
    end else begin
      req_b = 1'b1; we_b = we; be_b = be; addr_b = addr; wdata_b = wdata;
    end
  endtask

  task automatic idle();
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One accepted access followed by an idle; response is visible on return.
  task automatic access(input bit port_b, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    applyStimulus(port_b, we, be, addr, wdata);
    cycle();
    idle();
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    idle();
    we_a = 0; we_b = 0; be_a = 0; be_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    repeat (3) cycle();
    checkOutput("reset rvalid_a", 32'(rvalid_a), 0);
    checkOutput("reset rvalid_b", 32'(rvalid_b), 0);
    checkOutput("reset err_a", 32'(err_a), 0);
    checkOutput("reset rdata_b", rdata_b, 0);

`ifdef DUALRAM_CLEAR_EN
    checkOutput("busy in reset", 32'(init_busy), 1);
    checkOutput("ready in reset", 32'(ready_a), 0);
    rst = 1'b0;
    countBusy(n);
    checkOutput("clear cycles", 32'(n), 16);
    checkOutput("ready after clear", 32'(ready_a), 1);
    access(0, 0, 4'h0, B + 5, 0);
    checkOutput("cleared word 5", rdata_a, 32'h0);
    access(1, 1, 4'hF, B + 9, 32'h5555AAAA);
    // Reset seven cycles into the clear; clearing must restart from index 0.
    rst = 1'b1; cycle(); rst = 1'b0;
    repeat (7) cycle();
    checkOutput("busy mid clear", 32'(init_busy), 1);
    rst = 1'b1; cycle(); rst = 1'b0;
    countBusy(n);
    checkOutput("restart clear cycles", 32'(n), 16);
    access(1, 0, 4'h0, B + 9, 0);
    checkOutput("recleared word 9", rdata_b, 32'h0);
`else
    rst = 1'b0;
    cycle();
    checkOutput("ready after reset", 32'(ready_a), 1);
    checkOutput("init_busy tied low", 32'(init_busy), 0);
`endif

    // Byte-enable writes at BASE+3.
    access(0, 1, 4'hF, B + 3, 32'hAABBCCDD);
    checkOutput("write ack rvalid", 32'(rvalid_a), 1);
    checkOutput("write ack rdata", rdata_a, 0);
    checkOutput("write ack err", 32'(err_a), 0);
    access(0, 1, 4'b0101, B + 3, 32'h11223344);
    access(0, 0, 4'h0, B + 3, 0);
    checkOutput("byte write rvalid", 32'(rvalid_a), 1);
    checkOutput("byte write rdata", rdata_a, 32'hAA22CC44);
    cycle();
    checkOutput("rvalid one cycle", 32'(rvalid_a), 0);

    // be=0 write is acknowledged but changes nothing.
    access(0, 1, 4'h0, B + 3, 32'hFFFFFFFF);
    checkOutput("be0 ack", 32'(rvalid_a), 1);
    access(1, 0, 4'h0, B + 3, 0);
    checkOutput("be0 no change", rdata_b, 32'hAA22CC44);

    // Same-index collision: A owns byte 0, B fills the rest.
    applyStimulus(0, 1, 4'b0001, B + 4, 32'h000000FF);
    applyStimulus(1, 1, 4'hF,    B + 4, 32'h12345678);
    cycle(); idle();
    checkOutput("collision ack b", 32'(rvalid_b), 1);
    access(1, 0, 4'h0, B + 4, 0);
    checkOutput("collision word", rdata_b, 32'h123456FF);

    // Read-first, both port pairings.
    access(0, 1, 4'hF, B + 6, 32'h5);
    applyStimulus(0, 0, 4'h0, B + 6, 0);
    applyStimulus(1, 1, 4'hF, B + 6, 32'h9);
    cycle(); idle();
    checkOutput("read-first a", rdata_a, 32'h5);
    checkOutput("read-first b ack", rdata_b, 32'h0);
    access(1, 0, 4'h0, B + 6, 0);
    checkOutput("after write 9", rdata_b, 32'h9);
    applyStimulus(1, 0, 4'h0, B + 6, 0);
    applyStimulus(0, 1, 4'hF, B + 6, 32'hA);
    cycle(); idle();
    checkOutput("read-first b", rdata_b, 32'h9);
    access(0, 0, 4'h0, B + 6, 0);
    checkOutput("after write A", rdata_a, 32'hA);

    // Range: out-of-range writes would alias indices 15 and 0 if the check relied on wrap.
    access(0, 1, 4'hF, B + 0,  32'h0BADF00D);
    access(1, 1, 4'hF, B + 15, 32'h600DCAFE);
    checkOutput("top index err", 32'(err_b), 0);
    access(0, 1, 4'hF, B - 1, 32'hDEADBEEF);
    checkOutput("below base rvalid", 32'(rvalid_a), 1);
    checkOutput("below base err", 32'(err_a), 1);
    access(1, 1, 4'hF, B + 16, 32'hDEADBEEF);
    checkOutput("above top err", 32'(err_b), 1);
    access(1, 0, 4'h0, B + 16, 0);
    checkOutput("oor read err", 32'(err_b), 1);
    checkOutput("oor read rdata", rdata_b, 32'h0);
    access(0, 0, 4'h0, 32'h0, 0);
    checkOutput("addr zero err", 32'(err_a), 1);
    access(0, 0, 4'h0, B + 0, 0);
    checkOutput("index 0 unchanged", rdata_a, 32'h0BADF00D);
    checkOutput("index 0 err", 32'(err_a), 0);
    access(0, 0, 4'h0, B + 15, 0);
    checkOutput("index 15 unchanged", rdata_a, 32'h600DCAFE);

    // A request coinciding with reset must not produce a response.
    applyStimulus(0, 0, 4'h0, B + 0, 0);
    rst = 1'b1;
    cycle();
    idle();
    checkOutput("rst drops response", 32'(rvalid_a), 0);
    checkOutput("rst clears rdata", rdata_a, 32'h0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dualram_bank.md
DUALRAM_BANK -- requirements
Module: dualram_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words.
REQ-003 SHALL have parameter BASE, default 206800, byte-agnostic word address mapped to index 0.
REQ-004 SHALL have parameter AW, default 32, address port width.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have ports req_a, req_b  input  1  request valid per port.
REQ-008 SHALL have ports we_a, we_b  input  1  1 = write, 0 = read.
REQ-009 SHALL have ports be_a, be_b  input  WIDTH/8  byte write enables; ignored on reads.
REQ-010 SHALL have ports addr_a, addr_b  input  AW  word address; index = addr - BASE.
REQ-011 SHALL have ports wdata_a, wdata_b  input  WIDTH  write data.
REQ-012 SHALL have ports ready_a, ready_b  output  1  request accepted when req & ready.
REQ-013 SHALL have ports rvalid_a, rvalid_b  output  1  one-cycle response strobe.
REQ-014 SHALL have ports rdata_a, rdata_b  output  WIDTH  read data, valid with rvalid.
REQ-015 SHALL have ports err_a, err_b  output  1  out-of-range flag, valid with rvalid.
REQ-016 SHALL have port init_busy  output  1  high while memory clear is in progress.

Function
REQ-017 SHALL accept a request on a port in cycle N when req & ready are both high; other cycles ignore inputs.
REQ-018 SHALL assert rvalid for exactly one cycle at N+1 for every accepted request, reads and writes alike.
REQ-019 SHALL return the addressed word on rdata at N+1 for reads; rdata = 0 for write acknowledges.
REQ-020 SHALL treat addr < BASE or addr >= BASE+DEPTH as out of range: no memory change, rdata = 0, err = 1 with rvalid.
REQ-021 SHALL write only bytes whose be bit is 1; be = 0 write is a legal no-op acknowledged normally.
REQ-022 SHALL, on simultaneous writes to the same index, give port A priority per byte: B's byte written only where be_a bit is 0.
REQ-023 SHALL be read-first: a read and a write to the same index in the same cycle (either port pairing) return the pre-write word.
REQ-024 SHALL compute index with AW-bit unsigned subtraction; underflow detected by addr < BASE comparison, never by wrap.
REQ-025 SHALL implement FSM states S_CLEAR and S_RUN; ready_a/ready_b = 0 in S_CLEAR, 1 in S_RUN.
REQ-026 SHALL, in S_CLEAR, write zero to index clr_idx each cycle, clr_idx counting 0..DEPTH-1 ($clog2(DEPTH) bits), then transition to S_RUN.
REQ-027 SHALL drive init_busy = 1 exactly while in S_CLEAR.

Reset
REQ-028 SHALL on rst force rvalid_a/b = 0, err_a/b = 0, rdata_a/b = 0, clr_idx = 0, state = S_CLEAR (or S_RUN per REQ-030).
REQ-029 SHALL, on rst asserted mid-clear or mid-transaction, discard any pending response and restart clearing from index 0; memory contents are not otherwise reset.

Configuration
REQ-030 SHALL compile the clear FSM only when macro DUALRAM_CLEAR_EN is defined; without it, reset enters S_RUN directly, init_busy is tied 0, ready is 1 the cycle after reset, memory content undefined until written.

Structure
REQ-031 SHALL take default WIDTH/DEPTH/BASE constants and the state enum type (S_CLEAR, S_RUN) from shared package dualram_pkg.
REQ-032 SHALL instantiate sub-module dualram_port twice (A, B): range check, index generation, response register (rvalid/rdata/err).

Verification
REQ-033 SHALL cover clear: DEPTH=16, release rst -> init_busy high 16 cycles, ready rises cycle 17, read any index -> 0x00000000.
REQ-034 SHALL cover byte write: write 0xAABBCCDD be=1111 then 0x11223344 be=0101 at BASE+3 -> read returns 0xAA22CC44, latency 1.
REQ-035 SHALL cover collision: A writes 0x000000FF be=0001, B writes 0x12345678 be=1111 same index same cycle -> read 0x123456FF.
REQ-036 SHALL cover read-first: word 0x5, A reads while B writes 0x9 same index -> rdata_a = 0x5, next read 0x9.
REQ-037 SHALL cover range: access addr BASE-1 and BASE+DEPTH -> rvalid with err=1, rdata=0, memory unchanged; rst during clear at clr_idx=7 restarts at 0.
